// File: rtl/matrix_multiply_pkg.sv
// Shared types for the matrix multiply sequencer: FSM states, the pipeline token
// that travels alongside RAM reads, and a counter sizing helper.
package matrix_multiply_pkg;

    localparam int MAX_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                      valid;
        logic                      first;
        logic                      last;
        logic [MAX_ADDR_WIDTH-1:0] z_addr;
    } token_t;

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/matrix_multiply_ctrl_delay.sv
// Fixed-depth shift register that delays control tokens so they line up with
// RAM read data.
module matrix_multiply_ctrl_delay
    import matrix_multiply_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  token_t tok_in,
    output token_t tok_out
);

    token_t [DEPTH-1:0] stage_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg[0] <= tok_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign tok_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/matrix_multiply_sequencer.sv
// Sequences one Z = X*Y product: walks (r,c,k) row-major, drives RAM read
// addresses, and lines up MAC enables and Z writes with the RAM read latency.
module matrix_multiply_sequencer
    import matrix_multiply_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int X_ROWS        = 5,
    parameter int Y_COLS        = 3,
    parameter int X_COLS_Y_ROWS = 4,
    parameter int RAM_LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic                  z_wen
);

    localparam int K  = X_COLS_Y_ROWS;
    localparam int RW = cnt_width(X_ROWS);
    localparam int CW = cnt_width(Y_COLS);
    localparam int KW = cnt_width(K);

    if (RAM_LATENCY < 1 || ADDR_WIDTH < 1 || ADDR_WIDTH > MAX_ADDR_WIDTH ||
        X_ROWS < 1 || Y_COLS < 1 || K < 1 ||
        longint'(X_ROWS) * longint'(K) > (longint'(1) << ADDR_WIDTH) ||
        longint'(K) * longint'(Y_COLS) > (longint'(1) << ADDR_WIDTH) ||
        longint'(X_ROWS) * longint'(Y_COLS) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_params
        $fatal(1, "matrix_multiply_sequencer: illegal parameter combination");
    end

    state_t                state_reg, state_next;
    logic [RW-1:0]         r_reg;
    logic [CW-1:0]         c_reg;
    logic [KW-1:0]         k_reg;
    logic [ADDR_WIDTH-1:0] x_base_reg, x_addr_reg, y_addr_reg, z_idx_reg, z_addr_reg;
    logic                  tuple_valid_reg, z_wen_reg, done_reg;
    logic                  last_k, last_c, last_r, final_tuple, launch, advance;
    token_t                issue_tok, mac_tok;

    assign last_k      = (k_reg == KW'(K - 1));
    assign last_c      = (c_reg == CW'(Y_COLS - 1));
    assign last_r      = (r_reg == RW'(X_ROWS - 1));
    assign final_tuple = last_r & last_c & last_k;
    assign launch      = (state_reg == IDLE) & start;
    assign advance     = (state_reg == ISSUE) & ~final_tuple;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE:    if (start)       state_next = ISSUE;
            ISSUE:   if (final_tuple) state_next = DRAIN;
            DRAIN:   if (done_reg)    state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Counters describe the tuple currently on x_addr/y_addr; addresses move by
    // running bases so no multiplier is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg <= '0; c_reg <= '0; k_reg <= '0;
            x_base_reg <= '0; x_addr_reg <= '0; y_addr_reg <= '0; z_idx_reg <= '0;
            tuple_valid_reg <= 1'b0;
        end else begin
            tuple_valid_reg <= launch | advance;
            if (launch) begin
                r_reg <= '0; c_reg <= '0; k_reg <= '0;
                x_base_reg <= '0; x_addr_reg <= '0; y_addr_reg <= '0; z_idx_reg <= '0;
            end else if (advance) begin
                if (!last_k) begin
                    k_reg      <= k_reg + KW'(1);
                    x_addr_reg <= x_addr_reg + ADDR_WIDTH'(1);
                    y_addr_reg <= y_addr_reg + ADDR_WIDTH'(Y_COLS);
                end else begin
                    k_reg     <= '0;
                    z_idx_reg <= z_idx_reg + ADDR_WIDTH'(1);
                    if (!last_c) begin
                        c_reg      <= c_reg + CW'(1);
                        x_addr_reg <= x_base_reg;
                        y_addr_reg <= ADDR_WIDTH'(c_reg) + ADDR_WIDTH'(1);
                    end else begin
                        c_reg      <= '0;
                        r_reg      <= r_reg + RW'(1);
                        x_base_reg <= x_base_reg + ADDR_WIDTH'(K);
                        x_addr_reg <= x_base_reg + ADDR_WIDTH'(K);
                        y_addr_reg <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        issue_tok        = '0;
        issue_tok.valid  = tuple_valid_reg;
        issue_tok.first  = (k_reg == '0);
        issue_tok.last   = last_k;
        issue_tok.z_addr = MAX_ADDR_WIDTH'(z_idx_reg);
    end

    matrix_multiply_ctrl_delay #(
        .DEPTH (RAM_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .tok_in  (issue_tok),
        .tok_out (mac_tok)
    );

    // The accumulator holds the finished element one cycle after its last MAC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_wen_reg  <= 1'b0;
            done_reg   <= 1'b0;
            z_addr_reg <= '0;
        end else begin
            z_wen_reg <= mac_tok.valid & mac_tok.last;
            done_reg  <= mac_tok.valid & mac_tok.last &
                         (mac_tok.z_addr == MAX_ADDR_WIDTH'(X_ROWS * Y_COLS - 1));
            if (mac_tok.valid & mac_tok.last) z_addr_reg <= mac_tok.z_addr[ADDR_WIDTH-1:0];
        end
    end

    assign x_addr  = x_addr_reg;
    assign y_addr  = y_addr_reg;
    assign mac_en  = mac_tok.valid;
    assign mac_clr = mac_tok.valid & mac_tok.first;
    assign z_addr  = z_addr_reg;
    assign z_wen   = z_wen_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_matrix_multiply_sequencer.sv
// Scoreboard bench: three sequencer configurations each drive behavioural RAMs
// and a MAC; expected MAC operands and Z results come from plain matrix loops.
module tb_matrix_multiply_sequencer;

    localparam int AW   = 8;
    localparam int NCFG = 3;

    function automatic int cfg_xr(input int i); return (i == 2) ? 2 : 5; endfunction
    function automatic int cfg_yc(input int i); return (i == 2) ? 2 : 3; endfunction
    function automatic int cfg_k (input int i); return (i == 2) ? 1 : 4; endfunction
    function automatic int cfg_l (input int i); return (i == 1) ? 3 : 1; endfunction

    typedef struct {
        int          cyc;
        bit          clr;
        int unsigned xv;
        int unsigned yv;
    } mac_exp_t;

    typedef struct {
        int          cyc;
        int unsigned addr;
        int unsigned data;
        bit          done;
    } z_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit fin [NCFG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int XR = cfg_xr(gi);
        localparam int YC = cfg_yc(gi);
        localparam int K  = cfg_k(gi);
        localparam int L  = cfg_l(gi);
        localparam int N  = XR * YC * K;

        logic          rst = 1'b1;
        logic          start = 1'b0;
        logic          busy, done, mac_en, mac_clr, z_wen;
        logic [AW-1:0] x_addr, y_addr, z_addr;

        matrix_multiply_sequencer #(
            .ADDR_WIDTH    (AW),
            .X_ROWS        (XR),
            .Y_COLS        (YC),
            .X_COLS_Y_ROWS (K),
            .RAM_LATENCY   (L)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .busy    (busy),
            .done    (done),
            .x_addr  (x_addr),
            .y_addr  (y_addr),
            .mac_en  (mac_en),
            .mac_clr (mac_clr),
            .z_addr  (z_addr),
            .z_wen   (z_wen)
        );

        int unsigned x_mem [256];
        int unsigned y_mem [256];
        int unsigned x_pipe [L];
        int unsigned y_pipe [L];
        int unsigned acc = 0;
        mac_exp_t    mac_q [$];
        z_exp_t      z_q [$];
        int          busy_lo = 0;
        int          busy_hi = -1;

        // Behavioural RAMs with L-cycle read latency feeding a registered MAC.
        always @(posedge clk) begin
            x_pipe[0] <= x_mem[x_addr];
            y_pipe[0] <= y_mem[y_addr];
            for (int i = 1; i < L; i++) begin
                x_pipe[i] <= x_pipe[i-1];
                y_pipe[i] <= y_pipe[i-1];
            end
            if (mac_en)
                acc <= mac_clr ? x_pipe[L-1] * y_pipe[L-1] : acc + x_pipe[L-1] * y_pipe[L-1];
        end

        // Monitor: pops expectations whenever the DUT presents mac_en or z_wen.
        always @(negedge clk) begin
            if (!rst) begin
                check($sformatf("cfg%0d busy@%0d", gi, cyc), busy, (cyc >= busy_lo && cyc <= busy_hi));
                if (mac_en) begin
                    if (mac_q.size() == 0) begin
                        check($sformatf("cfg%0d unexpected mac_en@%0d", gi, cyc), mac_en, 0);
                    end else begin
                        mac_exp_t m;
                        m = mac_q.pop_front();
                        check($sformatf("cfg%0d mac_cycle", gi), cyc, m.cyc);
                        check($sformatf("cfg%0d mac_clr@%0d", gi, cyc), mac_clr, m.clr);
                        check($sformatf("cfg%0d x_data@%0d", gi, cyc), x_pipe[L-1], m.xv);
                        check($sformatf("cfg%0d y_data@%0d", gi, cyc), y_pipe[L-1], m.yv);
                    end
                end else begin
                    check($sformatf("cfg%0d mac_clr_idle@%0d", gi, cyc), mac_clr, 0);
                end
                if (z_wen) begin
                    if (z_q.size() == 0) begin
                        check($sformatf("cfg%0d unexpected z_wen@%0d", gi, cyc), z_wen, 0);
                    end else begin
                        z_exp_t z;
                        z = z_q.pop_front();
                        check($sformatf("cfg%0d z_cycle", gi), cyc, z.cyc);
                        check($sformatf("cfg%0d z_addr@%0d", gi, cyc), z_addr, z.addr);
                        check($sformatf("cfg%0d z_data[%0d]", gi, z.addr), acc, z.data);
                        check($sformatf("cfg%0d done@%0d", gi, cyc), done, z.done);
                    end
                end else begin
                    check($sformatf("cfg%0d done_without_wen@%0d", gi, cyc), done, 0);
                end
            end
        end

        task automatic load_ramp();
            for (int i = 0; i < 256; i++) begin
                x_mem[i] = (i < XR * K) ? i + 1 : 0;
                y_mem[i] = (i < K * YC) ? i + 1 : 0;
            end
        endtask

        task automatic load_random();
            for (int i = 0; i < 256; i++) begin
                x_mem[i] = $urandom_range(0, 255);
                y_mem[i] = $urandom_range(0, 255);
            end
        endtask

        // Called at a negedge with the DUT idle: start is sampled at the end of cycle t.
        task automatic launch(output int t);
            int unsigned sum;
            t = cyc;
            start = 1'b1;
            for (int r = 0; r < XR; r++) begin
                for (int c = 0; c < YC; c++) begin
                    int e;
                    e = r * YC + c;
                    sum = 0;
                    for (int k = 0; k < K; k++) begin
                        mac_q.push_back('{cyc: t + 1 + L + e * K + k, clr: (k == 0),
                                          xv: x_mem[r * K + k], yv: y_mem[k * YC + c]});
                        sum += x_mem[r * K + k] * y_mem[k * YC + c];
                    end
                    z_q.push_back('{cyc: t + (e + 1) * K + L + 1, addr: e, data: sum,
                                    done: (e == XR * YC - 1)});
                end
            end
            busy_lo = t + 1;
            busy_hi = t + N + L + 1;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic pulse_start_at(input int when);
            while (cyc < when) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic wait_idle();
            int budget;
            budget = 0;
            while ((busy !== 1'b0 || z_q.size() != 0) && budget < 500) begin
                @(negedge clk);
                budget++;
            end
            check($sformatf("cfg%0d run_completes_in_budget", gi), budget < 500, 1);
        endtask

        initial begin
            int t;
            @(negedge clk);
            check($sformatf("cfg%0d reset busy", gi), busy, 0);
            check($sformatf("cfg%0d reset outputs", gi),
                  {done, mac_en, mac_clr, z_wen, x_addr, y_addr, z_addr}, 0);
            @(negedge clk);
            rst = 1'b0;
            load_ramp();
            while (cyc < 10) @(negedge clk);
            launch(t);
            if (gi == 0) begin
                pulse_start_at(t + 30);
                pulse_start_at(t + 50);
                wait_idle();
                // Reset in the middle of a random run.
                @(negedge clk);
                load_random();
                launch(t);
                while (cyc < t + 20) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check("cfg0 async_rst busy", busy, 0);
                check("cfg0 async_rst outputs",
                      {done, mac_en, mac_clr, z_wen, x_addr, y_addr, z_addr}, 0);
                mac_q.delete();
                z_q.delete();
                busy_hi = -1;
                @(negedge clk);
                #2 rst = 1'b0;
                repeat (30) @(negedge clk);
                launch(t);
                wait_idle();
            end else if (gi == 1) begin
                wait_idle();
                @(negedge clk);
                load_random();
                launch(t);
                wait_idle();
            end else begin
                int budget;
                budget = 0;
                while (done !== 1'b1 && budget < 100) begin
                    @(negedge clk);
                    budget++;
                end
                check("cfg2 first_run_done_seen", done, 1);
                @(negedge clk);
                launch(t);
                wait_idle();
                @(negedge clk);
                load_random();
                launch(t);
                wait_idle();
            end
            repeat (5) @(negedge clk);
            check($sformatf("cfg%0d mac_queue_empty", gi), mac_q.size(), 0);
            check($sformatf("cfg%0d z_queue_empty", gi), z_q.size(), 0);
            fin[gi] = 1'b1;
        end
    end

    initial begin
        bit all_fin;
        all_fin = 1'b0;
        for (int i = 0; i < 3000 && !all_fin; i++) begin
            @(negedge clk);
            all_fin = fin[0] & fin[1] & fin[2];
        end
        check("all_configs_finished", all_fin, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
